// File: rtl/uart_wb_arb.sv
// uart_wb_arb: two-master Wishbone arbiter in front of a single UART slave.
// Round-robin grant with bus lock while the owner holds cyc; one IDLE cycle
// always separates two owners.
// Optional macro UART_ARB_TIMEOUT_EN adds a stalled-strobe watchdog that
// pulses the owner's err output and revokes the grant after TIMEOUT cycles.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no owner, slave bus parked at zero, arbitrating
// OWN0  | master 0 owns the slave bus
// OWN1  | master 1 owns the slave bus

`ifndef UART_ADDR_WIDTH
`define UART_ADDR_WIDTH 3
`endif

module uart_wb_arb #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        wb_rst_i,
  input  logic                        m0_cyc_i,
  input  logic                        m0_stb_i,
  input  logic                        m0_we_i,
  input  logic [`UART_ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [31:0]                 m0_dat_i,
  input  logic [3:0]                  m0_sel_i,
  output logic [31:0]                 m0_dat_o,
  output logic                        m0_ack_o,
  output logic                        m0_err_o,
  input  logic                        m1_cyc_i,
  input  logic                        m1_stb_i,
  input  logic                        m1_we_i,
  input  logic [`UART_ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [31:0]                 m1_dat_i,
  input  logic [3:0]                  m1_sel_i,
  output logic [31:0]                 m1_dat_o,
  output logic                        m1_ack_o,
  output logic                        m1_err_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [`UART_ADDR_WIDTH-1:0] s_adr_o,
  output logic [31:0]                 s_dat_o,
  output logic [3:0]                  s_sel_o,
  input  logic [31:0]                 s_dat_i,
  input  logic                        s_ack_i,
  output logic [1:0]                  gnt_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   expire;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("uart_wb_arb: TIMEOUT must be within 2..255");
  end

  // State and last-served pointer; last=1 after reset so master 0 wins first.
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state: round-robin in IDLE, hold while owner's cyc stays high.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i || expire) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i || expire) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave-side mux and ack steering; nothing reaches the slave in IDLE.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    gnt_o    = 2'b00;
    case (state_q)
      OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
        gnt_o    = 2'b01;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
        gnt_o    = 2'b10;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; the ack alone says whose it is.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

`ifdef UART_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       stall;
  logic       err0_q, err1_q;

  assign stall  = !s_ack_i && ((state_q == OWN0 && m0_stb_i) ||
                               (state_q == OWN1 && m1_stb_i));
  assign expire = stall && (cnt_q == 8'(TIMEOUT - 1));

  // Stall counter and one-cycle err pulse to the owner that timed out.
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      cnt_q  <= 8'd0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      err0_q <= expire && (state_q == OWN0);
      err1_q <= expire && (state_q == OWN1);
      if (expire || !stall || state_d == IDLE) cnt_q <= 8'd0;
      else                                     cnt_q <= cnt_q + 8'd1;
    end
  end

  assign m0_err_o = err0_q;
  assign m1_err_o = err1_q;
`else
  assign expire   = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_wb_arb.sv
// Directed bench for uart_wb_arb: expectations are queued as each step is
// driven and popped in order when the observed value is sampled mid-cycle.

`ifndef UART_ADDR_WIDTH
`define UART_ADDR_WIDTH 3
`endif

module tb_uart_wb_arb;
  localparam int AW = `UART_ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          wb_rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_adr_i;
  logic [31:0]   m0_dat_i;
  logic [3:0]    m0_sel_i;
  logic [31:0]   m0_dat_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_adr_i;
  logic [31:0]   m1_dat_i;
  logic [3:0]    m1_sel_i;
  logic [31:0]   m1_dat_o;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [31:0]   s_dat_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_dat_i;
  logic          s_ack_i;
  logic [1:0]    gnt_o;

  uart_wb_arb #(.TIMEOUT(16)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %0h with no expected value queued", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i = 1'b1;
    {m0_cyc_i, m0_stb_i, m0_we_i} = 3'b000;
    {m1_cyc_i, m1_stb_i, m1_we_i} = 3'b000;
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    s_dat_i  = 32'hDEAD_BEEF;
    s_ack_i  = 1'b0;

    // Reset values, with a master already requesting and the slave acking.
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1;
    exp_push("rst_gnt", 32'd0);
    exp_push("rst_s_cyc", 32'd0);
    exp_push("rst_s_stb", 32'd0);
    exp_push("rst_m0_ack", 32'd0);
    exp_push("rst_m0_err", 32'd0);
    exp_push("rst_m1_err", 32'd0);
    exp_push("rst_m0_dat", 32'hDEAD_BEEF);
    exp_push("rst_m1_dat", 32'hDEAD_BEEF);
    @(negedge clk);
    chk(32'(gnt_o)); chk(32'(s_cyc_o)); chk(32'(s_stb_o)); chk(32'(m0_ack_o));
    chk(32'(m0_err_o)); chk(32'(m1_err_o)); chk(m0_dat_o); chk(m1_dat_o);
    step();
    wb_rst_i = 1'b0;
    {m0_cyc_i, m0_stb_i} = 2'b00; s_ack_i = 1'b0;

    // Single write from m0: adr 3, data 0x41, granted one cycle later.
    step();
    {m0_cyc_i, m0_stb_i, m0_we_i} = 3'b111;
    m0_adr_i = AW'(3); m0_dat_i = 32'h41; m0_sel_i = 4'hF;
    exp_push("lat_gnt_idle", 32'd0);
    exp_push("lat_s_cyc_idle", 32'd0);
    @(negedge clk);
    chk(32'(gnt_o)); chk(32'(s_cyc_o));
    step();
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    exp_push("w_gnt", 32'd1);
    exp_push("w_adr", 32'd3);
    exp_push("w_dat", 32'h41);
    exp_push("w_we", 32'd1);
    exp_push("w_sel", 32'hF);
    exp_push("w_m0_ack", 32'd1);
    exp_push("w_m1_ack", 32'd0);
    exp_push("w_m1_dat", 32'h1234_5678);
    @(negedge clk);
    chk(32'(gnt_o)); chk(32'(s_adr_o)); chk(s_dat_o); chk(32'(s_we_o));
    chk(32'(s_sel_o)); chk(32'(m0_ack_o)); chk(32'(m1_ack_o)); chk(m1_dat_o);
    step();
    {m0_cyc_i, m0_stb_i, m0_we_i} = 3'b000; s_ack_i = 1'b0;
    step();
    exp_push("rel_gnt", 32'd0);
    @(negedge clk);
    chk(32'(gnt_o));

    // Fresh reset, then simultaneous requests: m0 first, one IDLE gap, m1.
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = AW'(5);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = AW'(6);
    step();
    s_ack_i = 1'b1;
    exp_push("both_gnt", 32'd1);
    exp_push("both_m0_ack", 32'd1);
    exp_push("both_m1_ack", 32'd0);
    exp_push("both_adr", 32'd5);
    @(negedge clk);
    chk(32'(gnt_o)); chk(32'(m0_ack_o)); chk(32'(m1_ack_o)); chk(32'(s_adr_o));
    step();
    {m0_cyc_i, m0_stb_i} = 2'b00; s_ack_i = 1'b0;
    step();
    exp_push("gap_gnt", 32'd0);
    exp_push("gap_s_cyc", 32'd0);
    @(negedge clk);
    chk(32'(gnt_o)); chk(32'(s_cyc_o));
    step();
    exp_push("m1_gnt", 32'd2);
    exp_push("m1_adr", 32'd6);
    @(negedge clk);
    chk(32'(gnt_o)); chk(32'(s_adr_o));

    // m1 locks the bus for three strobes while m0 waits.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = AW'(5);
    for (int i = 0; i < 3; i++) begin
      step();
      m1_stb_i = 1'b1; s_ack_i = 1'b1;
      exp_push("lock_m0_ack", 32'd0);
      exp_push("lock_m1_ack", 32'd1);
      exp_push("lock_gnt", 32'd2);
      exp_push("lock_adr", 32'd6);
      @(negedge clk);
      chk(32'(m0_ack_o)); chk(32'(m1_ack_o)); chk(32'(gnt_o)); chk(32'(s_adr_o));
      step();
      m1_stb_i = 1'b0; s_ack_i = 1'b0;
      exp_push("lock_gap_stb", 32'd0);
      exp_push("lock_gap_gnt", 32'd2);
      @(negedge clk);
      chk(32'(s_stb_o)); chk(32'(gnt_o));
    end
    step();
    m1_cyc_i = 1'b0; s_ack_i = 1'b1;
    exp_push("drop_m0_ack", 32'd0);
    @(negedge clk);
    chk(32'(m0_ack_o));
    step();
    s_ack_i = 1'b0;
    exp_push("drop_gap_gnt", 32'd0);
    @(negedge clk);
    chk(32'(gnt_o));
    step();
    exp_push("m0_after_gnt", 32'd1);
    exp_push("m0_after_adr", 32'd5);
    @(negedge clk);
    chk(32'(gnt_o)); chk(32'(s_adr_o));

    // Leave last=0, regrant m0 alone, then reset mid-OWN0 with both waiting.
    step();
    m0_cyc_i = 1'b0;
    step();
    m0_cyc_i = 1'b1;
    step();
    exp_push("pre_rst_gnt", 32'd1);
    @(negedge clk);
    chk(32'(gnt_o));
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0; s_ack_i = 1'b1;
    exp_push("abort_gnt", 32'd0);
    exp_push("abort_s_cyc", 32'd0);
    exp_push("abort_m0_ack", 32'd0);
    exp_push("abort_m1_ack", 32'd0);
    @(negedge clk);
    chk(32'(gnt_o)); chk(32'(s_cyc_o)); chk(32'(m0_ack_o)); chk(32'(m1_ack_o));
    step();
    s_ack_i = 1'b0;
    exp_push("abort_last_gnt", 32'd1);
    @(negedge clk);
    chk(32'(gnt_o));

    // m0 leaves; m1 strobes into a slave that never acks.
    step();
    {m0_cyc_i, m0_stb_i} = 2'b00;
    step();
    step();
    exp_push("to_grant", 32'd2);
    @(negedge clk);
    chk(32'(gnt_o));
    for (int i = 1; i < 16; i++) begin
      step();
      exp_push("to_wait_err", 32'd0);
      exp_push("to_wait_gnt", 32'd2);
      @(negedge clk);
      chk(32'(m1_err_o)); chk(32'(gnt_o));
    end
    step();
`ifdef UART_ARB_TIMEOUT_EN
    exp_push("to_m1_err", 32'd1);
    exp_push("to_m0_err", 32'd0);
    exp_push("to_gnt", 32'd0);
`else
    exp_push("to_m1_err", 32'd0);
    exp_push("to_m0_err", 32'd0);
    exp_push("to_gnt", 32'd2);
`endif
    @(negedge clk);
    chk(32'(m1_err_o)); chk(32'(m0_err_o)); chk(32'(gnt_o));
    step();
    exp_push("to_err_once", 32'd0);
    @(negedge clk);
    chk(32'(m1_err_o));

    step();
    {m1_cyc_i, m1_stb_i} = 2'b00;
    step();
    step();
    exp_push("end_gnt", 32'd0);
    @(negedge clk);
    chk(32'(gnt_o));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
